rs_bank: RTL and testbench

//  Receiving end of the issue-stage RS packet interface: holds NUM_RS reservation

---
 rtl/rs_bank_pkg.sv | 44 ++++
 rtl/rs_rr_arbiter.sv | 38 +++
 rtl/rs_bank.sv | 135 +++++++++++++
 tb/tb_rs_bank.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_bank_pkg.sv
// Shared issue-stage types: RS packet, ALU op and branch encodings, tag width.
// Combinational helpers only, no latency or backpressure of its own.
package rs_bank_pkg;

  localparam int XLEN  = 32;
  localparam int TAG_W = 3;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_JAL  = 2'b11
  } branch_t;

  typedef struct packed {
    logic [TAG_W-1:0] q_j;
    logic [TAG_W-1:0] q_k;
    logic [XLEN-1:0]  v_j;
    logic [XLEN-1:0]  v_k;
    logic [TAG_W-1:0] rob_entry;
    alu_op_t          alu_op;
    branch_t          branch_type;
    logic             busy;
  } rs_data_t;

  // Tag 0 means "value present", so it never wakes anything.
  function automatic logic tag_hit(input logic cdb_valid,
                                   input logic [TAG_W-1:0] cdb_tag,
                                   input logic [TAG_W-1:0] q);
    return cdb_valid && (cdb_tag != '0) && (cdb_tag == q);
  endfunction

endpackage

// File: rtl/rs_rr_arbiter.sv
// Round-robin pick among ready stations, starting the search at ptr.
// Purely combinational; no backpressure (caller decides whether to use the grant).
module rs_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 grant_vld
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] slot;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    sum       = '0;
    slot      = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N)) begin
        sum = sum - (IDX_W+1)'(N);
      end
      slot = sum[IDX_W-1:0];
      if (!grant_vld && req[slot]) begin
        grant_vld   = 1'b1;
        grant_idx   = slot;
        grant[slot] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_bank.sv
// Reservation-station bank: captures issued packets, snoops the CDB, dispatches one ready entry/cycle.
// alu_valid rises 1 cycle after a ready issue; output register holds payload while alu_ready is low.
module rs_bank
  import rs_bank_pkg::*;
#(
  parameter int NUM_RS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      issue_valid,
  input  logic [$clog2(NUM_RS)-1:0] rs_dest,
  input  rs_data_t                  rs_input,
  output logic [NUM_RS-1:0]         busy_bus,
  input  logic                      cdb_valid,
  input  logic [TAG_W-1:0]          cdb_tag,
  input  logic [XLEN-1:0]           cdb_value,
  input  logic                      flush,
  output logic                      alu_valid,
  input  logic                      alu_ready,
  output alu_op_t                   alu_op,
  output logic [XLEN-1:0]           alu_vj,
  output logic [XLEN-1:0]           alu_vk,
  output logic [TAG_W-1:0]          alu_rob,
  output branch_t                   alu_branch_type
);

  localparam int IDX_W = $clog2(NUM_RS);

  rs_data_t          st [NUM_RS];
  rs_data_t          issue_pkt;
  logic [NUM_RS-1:0] ready;
  logic [NUM_RS-1:0] grant;
  logic [IDX_W-1:0]  grant_idx;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  rr_next;
  logic              grant_vld;
  logic              out_load;
  logic              dispatch;

  always_comb begin
    busy_bus = '0;
    ready    = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      busy_bus[i] = st[i].busy;
      ready[i]    = st[i].busy && (st[i].q_j == '0) && (st[i].q_k == '0);
    end
  end

  // A producer broadcasting in the issue cycle must not be missed.
  always_comb begin
    issue_pkt      = rs_input;
    issue_pkt.busy = 1'b1;
    if (tag_hit(cdb_valid, cdb_tag, rs_input.q_j)) begin
      issue_pkt.v_j = cdb_value;
      issue_pkt.q_j = '0;
    end
    if (tag_hit(cdb_valid, cdb_tag, rs_input.q_k)) begin
      issue_pkt.v_k = cdb_value;
      issue_pkt.q_k = '0;
    end
  end

  rs_rr_arbiter #(.N(NUM_RS)) u_arb (
    .req       (ready),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign out_load = !alu_valid || alu_ready;
  assign dispatch = out_load && grant_vld;
  assign rr_next  = (grant_idx == IDX_W'(NUM_RS-1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_RS; i++) begin
        st[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_RS; i++) begin
        st[i].busy <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_RS; i++) begin
        if (st[i].busy && tag_hit(cdb_valid, cdb_tag, st[i].q_j)) begin
          st[i].v_j <= cdb_value;
          st[i].q_j <= '0;
        end
        if (st[i].busy && tag_hit(cdb_valid, cdb_tag, st[i].q_k)) begin
          st[i].v_k <= cdb_value;
          st[i].q_k <= '0;
        end
        if (dispatch && grant[i]) begin
          st[i].busy <= 1'b0;
        end
        // Writes into an occupied station are dropped.
        if (issue_valid && (rs_dest == IDX_W'(i)) && !st[i].busy) begin
          st[i] <= issue_pkt;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_valid       <= 1'b0;
      alu_op          <= ALU_ADD;
      alu_vj          <= '0;
      alu_vk          <= '0;
      alu_rob         <= '0;
      alu_branch_type <= BR_NONE;
      rr_ptr          <= '0;
    end else if (flush) begin
      alu_valid <= 1'b0;
      rr_ptr    <= '0;
    end else if (out_load) begin
      alu_valid <= grant_vld;
      if (grant_vld) begin
        alu_op          <= st[grant_idx].alu_op;
        alu_vj          <= st[grant_idx].v_j;
        alu_vk          <= st[grant_idx].v_k;
        alu_rob         <= st[grant_idx].rob_entry;
        alu_branch_type <= st[grant_idx].branch_type;
        rr_ptr          <= rr_next;
      end
    end
  end

  issue_to_busy_station: assert property (
    @(posedge clk) disable iff (reset)
    (issue_valid && !flush) |-> !busy_bus[rs_dest]
  );

endmodule

// File: tb/tb_rs_bank.sv
// Bench for rs_bank: directed vector table, multi-cycle corner sequences, random run vs model.
module tb_rs_bank;
  import rs_bank_pkg::*;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            issue_valid;
  logic [1:0]      rs_dest;
  rs_data_t        rs_input;
  logic [N-1:0]    busy_bus;
  logic            cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0] cdb_value;
  logic            flush;
  logic            alu_valid;
  logic            alu_ready;
  alu_op_t         alu_op;
  logic [XLEN-1:0] alu_vj;
  logic [XLEN-1:0] alu_vk;
  logic [TAG_W-1:0] alu_rob;
  branch_t         alu_branch_type;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rs_bank #(.NUM_RS(N)) dut (
    .clk             (clk),
    .reset           (reset),
    .issue_valid     (issue_valid),
    .rs_dest         (rs_dest),
    .rs_input        (rs_input),
    .busy_bus        (busy_bus),
    .cdb_valid       (cdb_valid),
    .cdb_tag         (cdb_tag),
    .cdb_value       (cdb_value),
    .flush           (flush),
    .alu_valid       (alu_valid),
    .alu_ready       (alu_ready),
    .alu_op          (alu_op),
    .alu_vj          (alu_vj),
    .alu_vk          (alu_vk),
    .alu_rob         (alu_rob),
    .alu_branch_type (alu_branch_type)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    issue_valid = 1'b0;
    rs_dest     = 2'd0;
    rs_input    = '0;
    cdb_valid   = 1'b0;
    cdb_tag     = '0;
    cdb_value   = '0;
    flush       = 1'b0;
  endtask

  function automatic rs_data_t mk_pkt(input int qj, input int qk, input logic [31:0] vj,
                                      input logic [31:0] vk, input int rob, input int op,
                                      input int br);
    rs_data_t p;
    p.q_j         = 3'(qj);
    p.q_k         = 3'(qk);
    p.v_j         = vj;
    p.v_k         = vk;
    p.rob_entry   = 3'(rob);
    p.alu_op      = alu_op_t'(3'(op));
    p.branch_type = branch_t'(2'(br));
    p.busy        = 1'b1;
    return p;
  endfunction

  task automatic drive_issue(input int slot, input rs_data_t p);
    issue_valid = 1'b1;
    rs_dest     = 2'(slot);
    rs_input    = p;
  endtask

  typedef struct {
    logic        iv;
    logic [1:0]  dest;
    rs_data_t    pkt;
    logic        cv;
    logic [2:0]  ctag;
    logic [31:0] cval;
    logic        ardy;
    logic        exp_valid;
    logic [3:0]  exp_busy;
    logic [31:0] exp_vj;
    logic [31:0] exp_vk;
    logic [2:0]  exp_rob;
  } vec_t;

  function automatic vec_t row(input int iv, input int dest, input int qj, input int qk,
                               input logic [31:0] vj, input logic [31:0] vk, input int rob,
                               input int cv, input int ctag, input logic [31:0] cval,
                               input int ev, input int ebusy, input logic [31:0] evj,
                               input logic [31:0] evk, input int erob);
    vec_t v;
    v.iv        = iv[0];
    v.dest      = dest[1:0];
    v.pkt       = mk_pkt(qj, qk, vj, vk, rob, 0, 0);
    v.cv        = cv[0];
    v.ctag      = ctag[2:0];
    v.cval      = cval;
    v.ardy      = 1'b1;
    v.exp_valid = ev[0];
    v.exp_busy  = ebusy[3:0];
    v.exp_vj    = evj;
    v.exp_vk    = evk;
    v.exp_rob   = erob[2:0];
    return v;
  endfunction

  // Reference model state: a plain array of stations plus the output slot.
  bit          m_busy [N];
  logic [2:0]  m_qj [N], m_qk [N], m_rob [N];
  logic [31:0] m_vj [N], m_vk [N];
  alu_op_t     m_op [N];
  branch_t     m_br [N];
  bit          m_valid;
  logic [31:0] m_ovj, m_ovk;
  logic [2:0]  m_orob;
  alu_op_t     m_oop;
  branch_t     m_obr;
  int          m_rr;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_busy[i] = 0;
    m_valid = 0;
    m_rr    = 0;
  endtask

  task automatic model_edge();
    bit pre [N];
    int pick;
    if (flush) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) pre[i] = m_busy[i];
    if (!m_valid || alu_ready) begin
      pick = -1;
      for (int k = 0; k < N; k++) begin
        int s;
        s = (m_rr + k) % N;
        if (pick < 0 && m_busy[s] && m_qj[s] == 0 && m_qk[s] == 0) pick = s;
      end
      m_valid = (pick >= 0);
      if (pick >= 0) begin
        m_ovj        = m_vj[pick];
        m_ovk        = m_vk[pick];
        m_orob       = m_rob[pick];
        m_oop        = m_op[pick];
        m_obr        = m_br[pick];
        m_busy[pick] = 0;
        m_rr         = (pick + 1) % N;
      end
    end
    if (cdb_valid && cdb_tag != 0) begin
      for (int i = 0; i < N; i++) begin
        if (pre[i] && m_qj[i] == cdb_tag) begin m_vj[i] = cdb_value; m_qj[i] = 0; end
        if (pre[i] && m_qk[i] == cdb_tag) begin m_vk[i] = cdb_value; m_qk[i] = 0; end
      end
    end
    if (issue_valid && !pre[rs_dest]) begin
      m_busy[rs_dest] = 1;
      m_qj[rs_dest]   = rs_input.q_j;
      m_qk[rs_dest]   = rs_input.q_k;
      m_vj[rs_dest]   = rs_input.v_j;
      m_vk[rs_dest]   = rs_input.v_k;
      m_rob[rs_dest]  = rs_input.rob_entry;
      m_op[rs_dest]   = rs_input.alu_op;
      m_br[rs_dest]   = rs_input.branch_type;
      if (cdb_valid && cdb_tag != 0 && rs_input.q_j == cdb_tag) begin
        m_vj[rs_dest] = cdb_value; m_qj[rs_dest] = 0;
      end
      if (cdb_valid && cdb_tag != 0 && rs_input.q_k == cdb_tag) begin
        m_vk[rs_dest] = cdb_value; m_qk[rs_dest] = 0;
      end
    end
  endtask

  vec_t tbl [14];

  initial begin
    logic [3:0] mb;
    int         free_l [N];
    int         free_n;

    tbl[0]  = row(1, 0, 0, 0, 32'd5, 32'd7, 3, 0, 0, 0,        0, 4'b0001, 0, 0, 0);
    tbl[1]  = row(0, 0, 0, 0, 0, 0, 0,        0, 0, 0,        1, 4'b0000, 32'd5, 32'd7, 3);
    tbl[2]  = row(1, 1, 2, 0, 0, 32'd9, 4,    0, 0, 0,        0, 4'b0010, 0, 0, 0);
    tbl[3]  = row(0, 0, 0, 0, 0, 0, 0,        0, 0, 0,        0, 4'b0010, 0, 0, 0);
    tbl[4]  = row(0, 0, 0, 0, 0, 0, 0,        1, 2, 32'h10,   0, 4'b0010, 0, 0, 0);
    tbl[5]  = row(0, 0, 0, 0, 0, 0, 0,        0, 0, 0,        1, 4'b0000, 32'h10, 32'd9, 4);
    tbl[6]  = row(1, 2, 0, 4, 32'd1, 0, 5,    1, 4, 32'h22,   0, 4'b0100, 0, 0, 0);
    tbl[7]  = row(0, 0, 0, 0, 0, 0, 0,        0, 0, 0,        1, 4'b0000, 32'd1, 32'h22, 5);
    tbl[8]  = row(0, 0, 0, 0, 0, 0, 0,        0, 0, 0,        0, 4'b0000, 0, 0, 0);
    tbl[9]  = row(1, 3, 1, 0, 0, 0, 6,        1, 0, 32'h55,   0, 4'b1000, 0, 0, 0);
    tbl[10] = row(0, 0, 0, 0, 0, 0, 0,        1, 0, 32'h66,   0, 4'b1000, 0, 0, 0);
    tbl[11] = row(0, 0, 0, 0, 0, 0, 0,        1, 1, 32'h77,   0, 4'b1000, 0, 0, 0);
    tbl[12] = row(0, 0, 0, 0, 0, 0, 0,        0, 0, 0,        1, 4'b0000, 32'h77, 32'd0, 6);
    tbl[13] = row(0, 0, 0, 0, 0, 0, 0,        0, 0, 0,        0, 4'b0000, 0, 0, 0);

    reset     = 1'b1;
    alu_ready = 1'b0;
    set_idle();
    step();
    chk("reset_busy",  64'(busy_bus),  64'(0));
    chk("reset_valid", 64'(alu_valid), 64'(0));
    chk("reset_vj",    64'(alu_vj),    64'(0));
    chk("reset_rob",   64'(alu_rob),   64'(0));
    reset = 1'b0;
    step();

    // Directed table: dispatch latency, CDB wakeup, same-cycle forwarding, tag 0.
    foreach (tbl[r]) begin
      set_idle();
      issue_valid = tbl[r].iv;
      rs_dest     = tbl[r].dest;
      rs_input    = tbl[r].pkt;
      cdb_valid   = tbl[r].cv;
      cdb_tag     = tbl[r].ctag;
      cdb_value   = tbl[r].cval;
      alu_ready   = tbl[r].ardy;
      step();
      chk($sformatf("tbl%0d_valid", r), 64'(alu_valid), 64'(tbl[r].exp_valid));
      chk($sformatf("tbl%0d_busy", r),  64'(busy_bus),  64'(tbl[r].exp_busy));
      if (tbl[r].exp_valid) begin
        chk($sformatf("tbl%0d_vj", r),  64'(alu_vj),  64'(tbl[r].exp_vj));
        chk($sformatf("tbl%0d_vk", r),  64'(alu_vk),  64'(tbl[r].exp_vk));
        chk($sformatf("tbl%0d_rob", r), 64'(alu_rob), 64'(tbl[r].exp_rob));
      end
    end
    set_idle();

    // Fill all slots with ALU stalled, hold 3 cycles, then drain in slot order 0..3.
    alu_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      set_idle();
      drive_issue(i, mk_pkt(0, 0, 32'h100 + i, 32'h200 + i, i, i, i));
      step();
    end
    set_idle();
    chk("fill_busy", 64'(busy_bus), 64'(4'b1110));
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stall_valid", 64'(alu_valid), 64'(1));
      chk("stall_vj",    64'(alu_vj),    64'(32'h100));
      chk("stall_busy",  64'(busy_bus),  64'(4'b1110));
    end
    alu_ready = 1'b1;
    for (int k = 1; k < N; k++) begin
      step();
      chk("drain_valid", 64'(alu_valid),       64'(1));
      chk("drain_vj",    64'(alu_vj),          64'(32'h100 + k));
      chk("drain_vk",    64'(alu_vk),          64'(32'h200 + k));
      chk("drain_op",    64'(alu_op),          64'(k));
      chk("drain_br",    64'(alu_branch_type), 64'(k));
    end
    step();
    chk("drain_end_valid", 64'(alu_valid), 64'(0));
    chk("drain_end_busy",  64'(busy_bus),  64'(0));

    // Flush with three busy stations, a held output and a concurrent issue.
    alu_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      set_idle();
      drive_issue(i, mk_pkt(0, 0, 32'h300 + i, 0, i, 0, 0));
      step();
    end
    set_idle();
    chk("preflush_busy",  64'(busy_bus),  64'(4'b1110));
    chk("preflush_valid", 64'(alu_valid), 64'(1));
    flush = 1'b1;
    drive_issue(0, mk_pkt(0, 0, 32'h3ff, 0, 7, 0, 0));
    step();
    set_idle();
    chk("flush_busy",  64'(busy_bus),  64'(0));
    chk("flush_valid", 64'(alu_valid), 64'(0));
    alu_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      chk("postflush_valid", 64'(alu_valid), 64'(0));
      chk("postflush_busy",  64'(busy_bus),  64'(0));
    end

    // Asynchronous reset between edges while a packet is on the ALU port.
    drive_issue(0, mk_pkt(0, 0, 32'h41, 0, 1, 0, 0));
    step();
    set_idle();
    drive_issue(1, mk_pkt(0, 0, 32'h42, 0, 2, 0, 0));
    step();
    set_idle();
    chk("predrst_valid", 64'(alu_valid), 64'(1));
    chk("predrst_busy",  64'(busy_bus),  64'(4'b0010));
    #2 reset = 1'b1;
    #1;
    chk("arst_busy",  64'(busy_bus),  64'(0));
    chk("arst_valid", 64'(alu_valid), 64'(0));
    chk("arst_vj",    64'(alu_vj),    64'(0));
    step();
    #2 reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("postrst_valid", 64'(alu_valid), 64'(0));
      chk("postrst_busy",  64'(busy_bus),  64'(0));
    end

    // Random traffic against the reference model, starting from the reset state.
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      set_idle();
      alu_ready = ($urandom_range(3) != 0);
      free_n = 0;
      for (int i = 0; i < N; i++) begin
        if (!m_busy[i]) begin
          free_l[free_n] = i;
          free_n++;
        end
      end
      if (free_n > 0 && $urandom_range(1) == 1) begin
        drive_issue(free_l[$urandom_range(free_n - 1)],
                    mk_pkt(($urandom_range(1) == 1) ? 0 : int'($urandom_range(7)),
                           ($urandom_range(1) == 1) ? 0 : int'($urandom_range(7)),
                           $urandom, $urandom, int'($urandom_range(7)),
                           int'($urandom_range(7)), int'($urandom_range(3))));
      end
      cdb_valid = ($urandom_range(2) == 0);
      cdb_tag   = 3'($urandom_range(7));
      cdb_value = $urandom;
      flush     = ($urandom_range(99) == 0);
      model_edge();
      step();
      for (int i = 0; i < N; i++) mb[i] = m_busy[i];
      chk("rnd_valid", 64'(alu_valid), 64'(m_valid));
      chk("rnd_busy",  64'(busy_bus),  64'(mb));
      if (m_valid) begin
        chk("rnd_vj",  64'(alu_vj),          64'(m_ovj));
        chk("rnd_vk",  64'(alu_vk),          64'(m_ovk));
        chk("rnd_rob", 64'(alu_rob),         64'(m_orob));
        chk("rnd_op",  64'(alu_op),          64'(m_oop));
        chk("rnd_br",  64'(alu_branch_type), 64'(m_obr));
      end
    end
    set_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
